// File: rtl/softstart_ramp_seq.sv
// Soft-start sequencer: deglitched enable, divided 0..ceil reference-DAC code ramp, fault abort, done flag.
// Define SOFTSTART_RAMPDOWN_EN to compile in the RAMPDN state (controlled ramp back to 0 on disable).
module softstart_ramp_seq #(
    parameter int CODE_W = 8,
    parameter int DIV_W  = 10,
    parameter int DGL_N  = 3
) (
    input  logic              CELCLK,
    input  logic              CELRST,
    input  logic              CELV,
    input  logic              CELG,
    input  logic              SUB,
    input  logic              en,
    input  logic              fault,
    input  logic [DIV_W-1:0]  div,
    input  logic [CODE_W-1:0] code_max,
    output logic [CODE_W-1:0] code,
    output logic              ramping,
    output logic              done,
    output logic              faulted
);

    localparam int DGL_CW = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RAMP   = 3'd1,
        S_DONE   = 3'd2,
`ifdef SOFTSTART_RAMPDOWN_EN
        S_RAMPDN = 3'd4,
`endif
        S_FAULT  = 3'd3
    } state_t;

    // Supply pins exist only for the schematic generator flow.
    logic unused_supply;
    assign unused_supply = CELV ^ CELG ^ SUB;

    state_t              state_reg, state_next;
    logic [CODE_W-1:0]   ceil_reg, ceil_next;
    logic [DIV_W-1:0]    div_cnt_reg, div_cnt_next;
    logic [CODE_W-1:0]   code_next;
    logic                ramping_next, done_next, faulted_next;
    logic [DGL_CW-1:0]   dgl_cnt_reg;
    logic                en_q;
    logic                div_hit;

    // en_q follows en only after en has differed from it for DGL_N consecutive clocks.
    always_ff @(posedge CELCLK or posedge CELRST) begin
        if (CELRST) begin
            dgl_cnt_reg <= '0;
            en_q        <= 1'b0;
        end else if (en == en_q) begin
            dgl_cnt_reg <= '0;
        end else if (dgl_cnt_reg == DGL_CW'(DGL_N - 1)) begin
            dgl_cnt_reg <= '0;
            en_q        <= en;
        end else begin
            dgl_cnt_reg <= dgl_cnt_reg + 1'b1;
        end
    end

    assign div_hit = (div_cnt_reg == div);

    always_ff @(posedge CELCLK or posedge CELRST) begin
        if (CELRST) begin
            state_reg   <= S_IDLE;
            ceil_reg    <= '0;
            div_cnt_reg <= '0;
            code        <= '0;
            ramping     <= 1'b0;
            done        <= 1'b0;
            faulted     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ceil_reg    <= ceil_next;
            div_cnt_reg <= div_cnt_next;
            code        <= code_next;
            ramping     <= ramping_next;
            done        <= done_next;
            faulted     <= faulted_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        ceil_next    = ceil_reg;
        div_cnt_next = '0;
        code_next    = code;
        case (state_reg)
            S_IDLE: begin
                code_next = '0;
                if (en_q && !fault) begin
                    ceil_next  = code_max;
                    state_next = (code_max == '0) ? S_DONE : S_RAMP;
                end
            end
            S_RAMP: begin
                if (fault) begin
                    state_next = S_FAULT;
                    code_next  = '0;
                end else if (!en_q) begin
`ifdef SOFTSTART_RAMPDOWN_EN
                    state_next = S_RAMPDN;
`else
                    state_next = S_IDLE;
                    code_next  = '0;
`endif
                end else if (div_hit) begin
                    // Free-running counter wraps if div shrank below it, so a step always comes.
                    if (code < ceil_reg)
                        code_next = code + 1'b1;
                    if (code_next >= ceil_reg)
                        state_next = S_DONE;
                end else begin
                    div_cnt_next = div_cnt_reg + 1'b1;
                end
            end
            S_DONE: begin
                code_next = ceil_reg;
                if (fault) begin
                    state_next = S_FAULT;
                    code_next  = '0;
                end else if (!en_q) begin
`ifdef SOFTSTART_RAMPDOWN_EN
                    state_next = S_RAMPDN;
`else
                    state_next = S_IDLE;
                    code_next  = '0;
`endif
                end
            end
`ifdef SOFTSTART_RAMPDOWN_EN
            S_RAMPDN: begin
                if (fault) begin
                    state_next = S_FAULT;
                    code_next  = '0;
                end else if (en_q) begin
                    ceil_next = code_max;
                    if (code >= code_max) begin
                        state_next = S_DONE;
                        code_next  = code_max;
                    end else begin
                        state_next = S_RAMP;
                    end
                end else if (code == '0) begin
                    state_next = S_IDLE;
                end else if (div_hit) begin
                    code_next = code - 1'b1;
                    if (code_next == '0)
                        state_next = S_IDLE;
                end else begin
                    div_cnt_next = div_cnt_reg + 1'b1;
                end
            end
`endif
            S_FAULT: begin
                code_next = '0;
                if (!en_q && !fault)
                    state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
                code_next  = '0;
            end
        endcase
    end

    // Flags are decoded from the next state so they register alongside code.
    always_comb begin
`ifdef SOFTSTART_RAMPDOWN_EN
        ramping_next = (state_next == S_RAMP) || (state_next == S_RAMPDN);
`else
        ramping_next = (state_next == S_RAMP);
`endif
        done_next    = (state_next == S_DONE);
        faulted_next = (state_next == S_FAULT);
    end

endmodule
